// File: rtl/fetch_if.sv
// fetch_if: instruction-memory, hazard/redirect and IF/ID bus of the fetch stage
interface fetch_if;
  logic [15:0] imem_addr;
  logic [31:0] instr_in;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [31:0] ifid_instr;
  logic [15:0] ifid_pc1;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;
  modport master (
    input  imem_addr, ifid_instr, ifid_pc1, ifid_valid, halted, fetch_count,
    output instr_in, stall, branch_taken, branch_target
  );
  modport slave (
    output imem_addr, ifid_instr, ifid_pc1, ifid_valid, halted, fetch_count,
    input  instr_in, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and IF/ID register; handles stall, branch redirect and halt on filler word
module fetch_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [31:0] INVALID_WORD = 32'h1234abcd,
  parameter logic [31:0] NOP_WORD     = 32'h00000000
) (
  input logic clk,
  input logic reset,
  fetch_if.slave bus
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt, w_pc_inc;
  logic [31:0] r_instr, w_instr_nxt;
  logic [15:0] r_pc1, w_pc1_nxt;
  logic        r_valid, w_valid_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  assign w_pc_inc = r_pc + 16'd1;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_instr <= NOP_WORD;
      r_pc1   <= 16'h0000;
      r_valid <= 1'b0;
      r_cnt   <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pc1   <= w_pc1_nxt;
      r_valid <= w_valid_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  // Priority: redirect > halted hold > stall > fetch; halted and stalled cases just hold.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_pc1_nxt   = r_pc1;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    if (bus.branch_taken) begin
      w_state_nxt = RUN;
      w_pc_nxt    = bus.branch_target;
      w_instr_nxt = NOP_WORD;
      w_pc1_nxt   = 16'h0000;
      w_valid_nxt = 1'b0;
    end else if (r_state == RUN && !bus.stall) begin
      if (bus.instr_in == INVALID_WORD) begin
        w_state_nxt = HALTED;
        w_instr_nxt = NOP_WORD;
        w_pc1_nxt   = 16'h0000;
        w_valid_nxt = 1'b0;
      end else begin
        w_pc_nxt    = w_pc_inc;
        w_instr_nxt = bus.instr_in;
        w_pc1_nxt   = w_pc_inc;
        w_valid_nxt = 1'b1;
        w_cnt_nxt   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
      end
    end
  end
  always_comb begin
    bus.imem_addr   = r_pc;
    bus.ifid_instr  = r_instr;
    bus.ifid_pc1    = r_pc1;
    bus.ifid_valid  = r_valid;
    bus.halted      = (r_state == HALTED);
    bus.fetch_count = r_cnt;
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch, stall, redirect, halt, wrap and reset
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  fetch_if bus();
  fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] imem(input logic [15:0] a);
    case (a)
      16'h0000: imem = 32'h8CE10010;
      16'h0001: imem = 32'h8CE20011;
      16'h0002: imem = 32'h00430820;
      16'h0003: imem = 32'hAC010012;
      16'h0004: imem = 32'h10210002;
      16'h0005: imem = 32'h20420001;
      16'hFFFF: imem = 32'h24010005;
      default:  imem = 32'h1234abcd;
    endcase
  endfunction
  always_comb bus.instr_in = imem(bus.imem_addr);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [15:0] pc1,
                          input logic v, input logic [15:0] addr, input logic [15:0] cnt, input logic h);
    chk({tag, ".instr"}, bus.ifid_instr, ins);
    chk({tag, ".pc1"}, {16'h0, bus.ifid_pc1}, {16'h0, pc1});
    chk({tag, ".valid"}, {31'h0, bus.ifid_valid}, {31'h0, v});
    chk({tag, ".addr"}, {16'h0, bus.imem_addr}, {16'h0, addr});
    chk({tag, ".count"}, {16'h0, bus.fetch_count}, {16'h0, cnt});
    chk({tag, ".halted"}, {31'h0, bus.halted}, {31'h0, h});
  endtask
  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 16'h0000;
    step();
    chk_ifid("rst", 32'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_ifid($sformatf("fetch%0d", i), imem(16'(i)), 16'(i + 1), 1'b1, 16'(i + 1), 16'(i + 1), 1'b0);
    end
    step();
    chk_ifid("halt", 32'h0, 16'h0, 1'b0, 16'h6, 16'h6, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bus.stall = i[0];
      step();
      chk_ifid($sformatf("hold%0d", i), 32'h0, 16'h0, 1'b0, 16'h6, 16'h6, 1'b1);
    end
    bus.stall = 1'b0;
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0000;
    step();
    chk_ifid("unhalt", 32'h0, 16'h0, 1'b0, 16'h0, 16'h6, 1'b0);
    bus.branch_taken = 1'b0;
    step();
    chk_ifid("refetch0", 32'h8CE10010, 16'h1, 1'b1, 16'h1, 16'h7, 1'b0);
    step();
    chk_ifid("refetch1", imem(16'h1), 16'h2, 1'b1, 16'h2, 16'h8, 1'b0);
    step();
    chk_ifid("refetch2", imem(16'h2), 16'h3, 1'b1, 16'h3, 16'h9, 1'b0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ifid($sformatf("stall%0d", i), imem(16'h2), 16'h3, 1'b1, 16'h3, 16'h9, 1'b0);
    end
    bus.stall = 1'b0;
    step();
    chk_ifid("resume", imem(16'h3), 16'h4, 1'b1, 16'h4, 16'hA, 1'b0);
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0001;
    step();
    chk_ifid("br_stall", 32'h0, 16'h0, 1'b0, 16'h1, 16'hA, 1'b0);
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    step();
    chk_ifid("br_tgt", imem(16'h1), 16'h2, 1'b1, 16'h2, 16'hB, 1'b0);
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'hFFFF;
    step();
    chk_ifid("br_ffff", 32'h0, 16'h0, 1'b0, 16'hFFFF, 16'hB, 1'b0);
    bus.branch_taken = 1'b0;
    step();
    chk_ifid("wrap", 32'h24010005, 16'h0, 1'b1, 16'h0, 16'hC, 1'b0);
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0006;
    step();
    bus.branch_taken = 1'b0;
    bus.stall = 1'b1;
    step();
    chk_ifid("stall_inv", 32'h0, 16'h0, 1'b0, 16'h6, 16'hC, 1'b0);
    bus.stall = 1'b0;
    step();
    chk_ifid("halt2", 32'h0, 16'h0, 1'b0, 16'h6, 16'hC, 1'b1);
    bus.stall = 1'b1;
    reset = 1'b1;
    step();
    chk_ifid("rst_halt", 32'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
